// File: rtl/xge_status_capture_if.sv
// rtl/xge_status_capture_if.sv - status capture signal bundle between MAC/PCS status and consumers
interface xge_status_capture_if;
  logic         tx_abs;
  logic         signal_detect;
  logic         areset_clk156;
  logic         areset_clk156_n;
  logic [7:0]   pcspma_status_in;
  logic [2:0]   mac_status_vector_in;
  logic [447:0] pcs_pma_status_vector_in;
  logic [7:0]   pcspma_status;
  logic [1:0]   mac_status_vector;
  logic [447:0] pcs_pma_status_vector;
  logic         status_full;
  logic         status_empty;
  // Read inhibit used only to exercise the full path; tie low in the wrapper.
  logic         rd_hold;

  modport master (
    output tx_abs, areset_clk156, pcspma_status_in, mac_status_vector_in,
           pcs_pma_status_vector_in, rd_hold,
    input  signal_detect, areset_clk156_n, pcspma_status, mac_status_vector,
           pcs_pma_status_vector, status_full, status_empty
  );

  modport slave (
    input  tx_abs, areset_clk156, pcspma_status_in, mac_status_vector_in,
           pcs_pma_status_vector_in, rd_hold,
    output signal_detect, areset_clk156_n, pcspma_status, mac_status_vector,
           pcs_pma_status_vector, status_full, status_empty
  );
endinterface

// File: rtl/xge_status_capture.sv
// rtl/xge_status_capture.sv - packs 10G status into a FWFT FIFO and registers the latest word
module xge_status_capture #(
  parameter int FIFO_DEPTH   = 16,
  parameter int STATUS_WIDTH = 458
) (
  input logic                core_clk,
  input logic                reset,
  xge_status_capture_if.slave st
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [STATUS_WIDTH-1:0] status_word;
  logic [STATUS_WIDTH-1:0] dout;
  logic [STATUS_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]             wr_ptr_q, wr_ptr_d;
  logic [AW:0]             rd_ptr_q, rd_ptr_d;
  logic                    status_full, status_empty;
  logic                    wr_en, rd_en;
  logic [7:0]              pcspma_q, pcspma_d;
  logic [1:0]              mac_q, mac_d;
  logic [447:0]            pcs_pma_q, pcs_pma_d;
  logic                    unused_mac_bit;

  assign st.signal_detect   = ~st.tx_abs;
  assign st.areset_clk156_n = ~st.areset_clk156;
  assign unused_mac_bit     = st.mac_status_vector_in[2];

  assign status_word = {st.pcs_pma_status_vector_in, st.mac_status_vector_in[1:0],
                        st.pcspma_status_in};

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign status_empty = (wr_ptr_q == rd_ptr_q);
  assign status_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign wr_en = !status_full && !reset;
  assign rd_en = !status_empty && !st.rd_hold && !reset;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pcspma_d  = pcspma_q;
    mac_d     = mac_q;
    pcs_pma_d = pcs_pma_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      pcs_pma_d = dout[457:10];
      mac_d     = dout[9:8];
      pcspma_d  = dout[7:0];
    end
  end

  always_ff @(posedge core_clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pcspma_q  <= '0;
      mac_q     <= '0;
      pcs_pma_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pcspma_q  <= pcspma_d;
      mac_q     <= mac_d;
      pcs_pma_q <= pcs_pma_d;
    end
  end

  always_ff @(posedge core_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= status_word;
    end
  end

  assign st.pcspma_status         = pcspma_q;
  assign st.mac_status_vector     = mac_q;
  assign st.pcs_pma_status_vector = pcs_pma_q;
  assign st.status_full           = status_full;
  assign st.status_empty          = status_empty;
endmodule

// File: tb/tb_xge_status_capture.sv
// tb/tb_xge_status_capture.sv - scoreboard bench for xge_status_capture
module tb_xge_status_capture;
  localparam int DEPTH = 4;

  logic core_clk = 1'b0;
  logic reset;
  always #5 core_clk = ~core_clk;

  xge_status_capture_if sif();

  xge_status_capture #(.FIFO_DEPTH(DEPTH), .STATUS_WIDTH(458)) dut (
    .core_clk (core_clk),
    .reset    (reset),
    .st       (sif)
  );

  logic [457:0] exp_q[$];
  logic [457:0] exp_out = '0;
  logic         mon_en  = 1'b0;
  int           errors  = 0;
  int           checks  = 0;

  task automatic chk(input string nm, input logic [457:0] act, input logic [457:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] p, input logic [2:0] m, input logic [447:0] v);
    sif.pcspma_status_in         = p;
    sif.mac_status_vector_in     = m;
    sif.pcs_pma_status_vector_in = v;
  endtask

  // Reference queue: words enter on write edges, leave into exp_out on read edges.
  always @(posedge core_clk) begin
    if (reset) begin
      exp_q.delete();
      exp_out = '0;
    end else begin
      automatic bit rd = (exp_q.size() > 0) && !sif.rd_hold;
      automatic bit wr = (exp_q.size() < DEPTH);
      if (rd) exp_out = exp_q.pop_front();
      if (wr) exp_q.push_back({sif.pcs_pma_status_vector_in,
                               sif.mac_status_vector_in[1:0], sif.pcspma_status_in});
    end
  end

  always @(negedge core_clk) begin
    if (mon_en) begin
      chk("sb_pcspma", 458'(sif.pcspma_status), 458'(exp_out[7:0]));
      chk("sb_mac", 458'(sif.mac_status_vector), 458'(exp_out[9:8]));
      chk("sb_vec", 458'(sif.pcs_pma_status_vector), 458'(exp_out[457:10]));
      chk("sb_empty", 458'(sif.status_empty), 458'(exp_q.size() == 0));
      chk("sb_full", 458'(sif.status_full), 458'(exp_q.size() == DEPTH));
    end
  end

  initial begin
    logic [7:0] full_exp [5];
    reset             = 1'b1;
    sif.rd_hold       = 1'b0;
    sif.tx_abs        = 1'b0;
    sif.areset_clk156 = 1'b1;
    set_in(8'($urandom()), 3'($urandom()), {14{$urandom()}});
    @(posedge core_clk);
    mon_en = 1'b1;
    repeat (3) begin
      @(negedge core_clk);
      set_in(8'($urandom()), 3'($urandom()), {14{$urandom()}});
      chk("rst_pcspma", 458'(sif.pcspma_status), 458'(0));
      chk("rst_vec", 458'(sif.pcs_pma_status_vector), 458'(0));
      chk("rst_empty", 458'(sif.status_empty), 458'(1));
      chk("rst_full", 458'(sif.status_full), 458'(0));
    end

    // Constant pattern; mac bit 2 must be dropped.
    reset = 1'b0;
    set_in(8'hA5, 3'b110, {56{8'h3C}});
    repeat (2) @(negedge core_clk);
    chk("const_pcspma", 458'(sif.pcspma_status), 458'(8'hA5));
    chk("const_mac", 458'(sif.mac_status_vector), 458'(2'b10));
    chk("const_vec", 458'(sif.pcs_pma_status_vector), 458'({56{8'h3C}}));
    repeat (3) @(negedge core_clk);
    chk("const_hold", 458'(sif.pcspma_status), 458'(8'hA5));

    // Incrementing stream with a one-cycle reset while 8'h40 is driven.
    for (int v = 0; v <= 8'h48; v++) begin
      @(negedge core_clk);
      if (v == 8'h41) begin
        chk("midrst_pcspma", 458'(sif.pcspma_status), 458'(0));
        chk("midrst_empty", 458'(sif.status_empty), 458'(1));
      end else if (v == 8'h42) begin
        chk("postrst_zero", 458'(sif.pcspma_status), 458'(0));
      end else if (v >= 2) begin
        chk("inc_track", 458'(sif.pcspma_status), 458'(8'(v - 2)));
        chk("inc_nonempty", 458'(sif.status_empty), 458'(0));
      end
      reset = (v == 8'h40);
      set_in(8'(v), 3'(v), {56{8'h3C}});
    end

    // Inverters under reset and out of reset.
    @(negedge core_clk);
    reset = 1'b1;
    sif.tx_abs = 1'b0; #1 chk("sd_0", 458'(sif.signal_detect), 458'(1));
    sif.tx_abs = 1'b1; #1 chk("sd_1", 458'(sif.signal_detect), 458'(0));
    sif.tx_abs = 1'b0; #1 chk("sd_2", 458'(sif.signal_detect), 458'(1));
    @(negedge core_clk);
    reset = 1'b0;
    sif.areset_clk156 = 1'b1; #1 chk("arn_0", 458'(sif.areset_clk156_n), 458'(0));
    sif.areset_clk156 = 1'b0; #1 chk("arn_1", 458'(sif.areset_clk156_n), 458'(1));

    // Fill the FIFO with reads held off, then drain.
    @(negedge core_clk);
    reset = 1'b1;
    sif.rd_hold = 1'b1;
    @(negedge core_clk);
    reset = 1'b0;
    set_in(8'hD0, 3'b001, {56{8'h11}});
    for (int i = 1; i < 4; i++) begin
      @(negedge core_clk);
      set_in(8'(8'hD0 + i), 3'(i), {56{8'h11}});
    end
    @(negedge core_clk);
    chk("fill_full", 458'(sif.status_full), 458'(1));
    chk("fill_empty", 458'(sif.status_empty), 458'(0));
    chk("fill_held", 458'(sif.pcspma_status), 458'(0));
    set_in(8'hD4, 3'b000, {56{8'h22}});
    @(negedge core_clk);
    chk("fill_full2", 458'(sif.status_full), 458'(1));
    set_in(8'hD5, 3'b000, {56{8'h22}});
    @(negedge core_clk);
    sif.rd_hold = 1'b0;
    set_in(8'hD6, 3'b000, {56{8'h22}});
    full_exp[0] = 8'hD0; full_exp[1] = 8'hD1; full_exp[2] = 8'hD2;
    full_exp[3] = 8'hD3; full_exp[4] = 8'hD7;
    for (int i = 0; i < 5; i++) begin
      @(negedge core_clk);
      chk("drain_order", 458'(sif.pcspma_status), 458'(full_exp[i]));
      set_in(8'(8'hD7 + i), 3'b000, {56{8'h33}});
    end
    repeat (6) @(negedge core_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
